// File: rtl/calc_pkg.sv
// Shared definitions for the signed-binary to three-digit BCD converter:
// FSM state encoding, digit count and default widths/limits.
package calc_pkg;

    localparam int BCD_DIGITS  = 3;
    localparam int BCD_W       = BCD_DIGITS * 4;
    localparam int BIN_W_DEF   = 11;
    localparam int MAX_MAG_DEF = 999;
    // Saturated magnitude always fits 10 bits, so double-dabble runs 10 iterations.
    localparam int SHIFT_BITS  = 10;
    localparam int SR_W        = BCD_W + SHIFT_BITS;
    localparam int ITER_W      = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ABS   = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: a BCD digit of 5 or more gets +3 so the
// following left shift carries correctly into the next decade.
module bcd_add3 (
    input  logic [3:0] digit_i,
    output logic [3:0] digit_o
);

    // Conditional +3 correction of one digit.
    always_comb begin
        digit_o = digit_i;
        if (digit_i >= 4'd5) begin
            digit_o = digit_i + 4'd3;
        end else begin
            digit_o = digit_i;
        end
    end

endmodule

// File: rtl/binary_to_bcd_converter.sv
// Converts a signed two's-complement ALU result into sign + saturated
// three-digit BCD magnitude using a sequential double-dabble engine.
module binary_to_bcd_converter
    import calc_pkg::*;
#(
    parameter int BIN_W   = BIN_W_DEF,
    parameter int MAX_MAG = MAX_MAG_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [BIN_W-1:0] alu_bin,
    output logic             busy,
    output logic             done,
    output logic [11:0]      alu_out,
    output logic             alu_sign,
    output logic             overflow,
    output logic             result_valid
);

    state_e                state_q,    state_d;
    logic [BIN_W-1:0]      bin_q,      bin_d;
    logic [SR_W-1:0]       sr_q,       sr_d;
    logic [ITER_W-1:0]     iter_q,     iter_d;
    logic                  sign_q,     sign_d;
    logic                  ovf_q,      ovf_d;
    logic [BCD_W-1:0]      alu_out_q,  alu_out_d;
    logic                  alu_sign_q, alu_sign_d;
    logic                  overflow_q, overflow_d;
    logic                  valid_q,    valid_d;
    logic                  busy_q,     busy_d;
    logic                  done_q,     done_d;

    logic [BIN_W-1:0]      mag_s;
    logic                  mag_ovf_s;
    logic [SHIFT_BITS-1:0] mag_sat_s;
    logic [SR_W-1:0]       corr_s;
    logic [SR_W-1:0]       shifted_s;

    // Magnitude of the captured operand; -2^(BIN_W-1) maps to 2^(BIN_W-1) unsigned.
    always_comb begin
        mag_s = bin_q;
        if (bin_q[BIN_W-1]) begin
            mag_s = (~bin_q) + {{(BIN_W-1){1'b0}}, 1'b1};
        end else begin
            mag_s = bin_q;
        end
        mag_ovf_s = (mag_s > BIN_W'(MAX_MAG));
        mag_sat_s = mag_ovf_s ? SHIFT_BITS'(MAX_MAG) : mag_s[SHIFT_BITS-1:0];
    end

    for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_add3
        bcd_add3 u_add3 (
            .digit_i(sr_q[SHIFT_BITS + 4*g +: 4]),
            .digit_o(corr_s[SHIFT_BITS + 4*g +: 4])
        );
    end
    assign corr_s[SHIFT_BITS-1:0] = sr_q[SHIFT_BITS-1:0];
    assign shifted_s = corr_s << 1;

    // Next-state and datapath update for the conversion FSM.
    always_comb begin
        state_d    = state_q;
        bin_d      = bin_q;
        sr_d       = sr_q;
        iter_d     = iter_q;
        sign_d     = sign_q;
        ovf_d      = ovf_q;
        alu_out_d  = alu_out_q;
        alu_sign_d = alu_sign_q;
        overflow_d = overflow_q;
        valid_d    = valid_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    bin_d   = alu_bin;
                    state_d = ABS;
                end else begin
                    state_d = IDLE;
                end
            end
            ABS: begin
                sr_d    = {{BCD_W{1'b0}}, mag_sat_s};
                sign_d  = bin_q[BIN_W-1] & (mag_s != {BIN_W{1'b0}});
                ovf_d   = mag_ovf_s;
                iter_d  = {ITER_W{1'b0}};
                state_d = SHIFT;
            end
            SHIFT: begin
                sr_d = shifted_s;
                if (iter_q == ITER_W'(SHIFT_BITS - 1)) begin
                    iter_d     = {ITER_W{1'b0}};
                    alu_out_d  = shifted_s[SR_W-1:SHIFT_BITS];
                    alu_sign_d = sign_q;
                    overflow_d = ovf_q;
                    valid_d    = 1'b1;
                    state_d    = DONE;
                end else begin
                    iter_d = iter_q + {{(ITER_W-1){1'b0}}, 1'b1};
                end
            end
            DONE: begin
                if (start) begin
                    bin_d   = alu_bin;
                    state_d = ABS;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d == ABS) || (state_d == SHIFT);
        // Pulse trails the DONE state so back-to-back pulses keep a 12-cycle pitch.
        done_d = (state_q == DONE);
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            bin_q      <= {BIN_W{1'b0}};
            sr_q       <= {SR_W{1'b0}};
            iter_q     <= {ITER_W{1'b0}};
            sign_q     <= 1'b0;
            ovf_q      <= 1'b0;
            alu_out_q  <= {BCD_W{1'b0}};
            alu_sign_q <= 1'b0;
            overflow_q <= 1'b0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bin_q      <= bin_d;
            sr_q       <= sr_d;
            iter_q     <= iter_d;
            sign_q     <= sign_d;
            ovf_q      <= ovf_d;
            alu_out_q  <= alu_out_d;
            alu_sign_q <= alu_sign_d;
            overflow_q <= overflow_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign alu_out      = alu_out_q;
    assign alu_sign     = alu_sign_q;
    assign overflow     = overflow_q;
    assign result_valid = valid_q;

endmodule

// File: tb/tb_binary_to_bcd_converter.sv
// Directed-vector bench: stimulus pushes expected results into a queue and a
// negedge monitor pops and compares them on every done pulse.
module tb_binary_to_bcd_converter;

    logic        clk;
    logic        rst;
    logic        start;
    logic [10:0] alu_bin;
    logic        busy;
    logic        done;
    logic [11:0] alu_out;
    logic        alu_sign;
    logic        overflow;
    logic        result_valid;

    typedef struct {
        logic [11:0] out;
        logic        sign;
        logic        ovf;
        int          due;
    } exp_t;

    exp_t q[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    binary_to_bcd_converter dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .alu_bin(alu_bin),
        .busy(busy),
        .done(done),
        .alu_out(alu_out),
        .alu_sign(alu_sign),
        .overflow(overflow),
        .result_valid(result_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Issue one start pulse; expected done lands 13 negedges after issue.
    task automatic issue(input logic [10:0] v, input logic [11:0] e_out,
                         input logic e_sign, input logic e_ovf);
        exp_t e;
        @(negedge clk);
        start   = 1'b1;
        alu_bin = v;
        e.out   = e_out;
        e.sign  = e_sign;
        e.ovf   = e_ovf;
        e.due   = cyc + 13;
        q.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40 && q.size() != 0; i++) @(negedge clk);
        @(negedge clk);
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL timeout: %0d results outstanding, expected 0", q.size());
            q.delete();
        end
    endtask

    // Monitor: compare every done pulse against the oldest expectation.
    always @(negedge clk) begin
        if (!rst && done) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 expected no pulse (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("alu_out", 32'(alu_out), 32'(e.out));
                check("alu_sign", 32'(alu_sign), 32'(e.sign));
                check("overflow", 32'(overflow), 32'(e.ovf));
                check("result_valid", 32'(result_valid), 32'd1);
                check("latency", 32'(cyc), 32'(e.due));
                check("digit_range", 32'((alu_out[11:8] <= 4'd9) && (alu_out[7:4] <= 4'd9)
                                         && (alu_out[3:0] <= 4'd9)), 32'd1);
            end
        end
    end

    initial begin
        rst     = 1'b1;
        start   = 1'b0;
        alu_bin = 11'd0;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_out", 32'(alu_out), 32'h000);
        check("rst_sign", 32'(alu_sign), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_valid", 32'(result_valid), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        issue(11'd123,  12'h123, 1'b0, 1'b0); wait_idle();
        issue(11'h7D3,  12'h045, 1'b1, 1'b0); wait_idle();
        issue(11'd0,    12'h000, 1'b0, 1'b0); wait_idle();
        issue(11'd999,  12'h999, 1'b0, 1'b0); wait_idle();
        issue(11'd1000, 12'h999, 1'b0, 1'b1); wait_idle();
        issue(11'h400,  12'h999, 1'b1, 1'b1); wait_idle();
        issue(11'h7FF,  12'h001, 1'b1, 1'b0); wait_idle();
        issue(11'd1023, 12'h999, 1'b0, 1'b1); wait_idle();
        issue(11'd680,  12'h680, 1'b0, 1'b0); wait_idle();

        // Start while busy must be ignored and the operand change must not leak in.
        issue(11'd57, 12'h057, 1'b0, 1'b0);
        @(negedge clk);
        check("busy_mid", 32'(busy), 32'd1);
        start   = 1'b1;
        alu_bin = 11'd88;
        @(negedge clk);
        start = 1'b0;
        wait_idle();
        repeat (14) @(negedge clk);

        // Second start during DONE: done pulses 12 cycles apart.
        issue(11'd200, 12'h200, 1'b0, 1'b0);
        repeat (10) @(negedge clk);
        issue(11'd345, 12'h345, 1'b0, 1'b0);
        wait_idle();

        // Reset during SHIFT iteration 5 aborts the conversion.
        issue(11'd321, 12'h321, 1'b0, 1'b0);
        repeat (5) @(negedge clk);
        check("hold_out", 32'(alu_out), 32'h345);
        check("busy_shift", 32'(busy), 32'd1);
        rst = 1'b1;
        q.delete();
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_out", 32'(alu_out), 32'h000);
        check("abort_valid", 32'(result_valid), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (16) @(negedge clk);
        check("post_rst_busy", 32'(busy), 32'd0);
        check("post_rst_valid", 32'(result_valid), 32'd0);
        issue(11'd321, 12'h321, 1'b0, 1'b0);
        wait_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/binary_to_bcd_converter.md
BINARY_TO_BCD_CONVERTER -- requirements
Module: binary_to_bcd_converter

Interface
REQ-001 Parameter BIN_W, default 11: width of the signed two's-complement ALU result input.
REQ-002 Parameter MAX_MAG, default 999: largest magnitude representable on three BCD digits.
REQ-003 clk  input  1  system clock; all state changes on the rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  one-cycle request to convert alu_bin; honoured only while busy=0.
REQ-006 alu_bin  input  BIN_W  signed two's-complement ALU result, sampled on the accepted start.
REQ-007 busy  output  1  high while a conversion is in progress.
REQ-008 done  output  1  one-cycle pulse when a new result is presented.
REQ-009 alu_out  output  12  three-digit BCD magnitude for the display output circuit: [11:8] hundreds, [7:4] tens, [3:0] units.
REQ-010 alu_sign  output  1  1 = negative result; feeds the display sign digit.
REQ-011 overflow  output  1  1 = magnitude exceeded MAX_MAG and alu_out is saturated.
REQ-012 result_valid  output  1  high once any conversion has completed since reset.

Function
REQ-013 The FSM SHALL have states IDLE, ABS, SHIFT and DONE.
- IDLE->ABS on start.
- ABS->SHIFT after 1 cycle.
- SHIFT->DONE after exactly 10 iterations.
- DONE->ABS if start is high, else DONE->IDLE.
REQ-014 busy SHALL be 1 in ABS and SHIFT and 0 in IDLE and DONE, so back-to-back conversions are possible every 12 cycles.
REQ-015 On an accepted start, alu_bin SHALL be captured into an internal register; later changes to alu_bin SHALL NOT affect the conversion.
REQ-016 start while busy=1 SHALL be ignored with no side effect.
REQ-017 ABS SHALL compute:
- sign = alu_bin[BIN_W-1];
- magnitude = |alu_bin|, as a BIN_W-bit unsigned value (-1024 yields 1024).
REQ-018 ABS SHALL set an internal overflow flag when magnitude > MAX_MAG and replace the magnitude with MAX_MAG.
REQ-019 SHIFT SHALL run double-dabble over a 12-bit BCD plus 10-bit binary shift register. In each of the 10 cycles, each BCD digit >= 5 gets +3, then the register shifts left by 1.
REQ-020 alu_out, alu_sign and overflow SHALL update only on the DONE entry edge and SHALL hold their values at all other times.
REQ-021 Latency: with start sampled at edge N, done SHALL be high during the cycle following edge N+12; the new alu_out is visible in that same cycle.
REQ-022 When the magnitude is 0, alu_sign SHALL be 0 (no negative zero).
REQ-023 result_valid SHALL be set on the first DONE and SHALL remain set until reset.
REQ-024 Every alu_out digit SHALL always be within 0..9.

Reset
REQ-025 On rst=1, asynchronously:
- state = IDLE;
- busy, done, alu_sign, overflow and result_valid = 0;
- alu_out = 12'h000;
- internal registers cleared.
REQ-026 A reset asserted mid-conversion SHALL abort it. After release the block SHALL be in IDLE with no done pulse, and the next start SHALL convert normally.

Structure
REQ-027 A shared package calc_pkg SHALL hold the FSM state enum, BCD_DIGITS=3, the default BIN_W and MAX_MAG.
REQ-028 The per-digit add-3 correction SHALL be a sub-module bcd_add3: 4-bit in, 4-bit out, purely combinational, instantiated three times.

Verification
REQ-029 alu_bin=123, start pulse -> 12 cycles later done=1, alu_out=12'h123, alu_sign=0, overflow=0, result_valid=1.
REQ-030 alu_bin=-45 (11'h7D3) -> alu_out=12'h045, alu_sign=1, overflow=0.
REQ-031 Boundaries:
- alu_bin=0 -> alu_out=12'h000, alu_sign=0;
- alu_bin=999 -> 12'h999, overflow=0;
- alu_bin=1000 -> 12'h999, overflow=1;
- alu_bin=-1024 -> 12'h999, alu_sign=1, overflow=1.
REQ-032 Busy/back-to-back handling:
- convert 57, then pulse start again while busy with alu_bin=88 -> ignored, result 12'h057, one done pulse only;
- start asserted during DONE -> the second conversion begins immediately, with done pulses exactly 12 cycles apart.
REQ-033 Reset mid-conversion: assert rst during SHIFT iteration 5 of a conversion of 321 -> all outputs cleared, no done; after release, converting 321 yields 12'h321.
